// File: rtl/sram_operand_reader.sv
// Burst reader: streams Length bytes from a 1-cycle-latency SRAM starting at Base_Addr
// into a small credit-controlled buffer feeding a valid/ready output stream.
module sram_operand_reader #(
    parameter int A_WIDTH    = 15,
    parameter int D_WIDTH    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [A_WIDTH-1:0] Base_Addr,
    input  logic [15:0]        Length,
    output logic               Busy,
    output logic               Done,
    output logic [A_WIDTH-1:0] Sram_Addr,
    output logic               Sram_En,
    output logic               Sram_RW,
    output logic [D_WIDTH-1:0] Sram_Data_In,
    input  logic [D_WIDTH-1:0] Sram_Data_Out,
    output logic [D_WIDTH-1:0] Out_Data,
    output logic               Out_Valid,
    input  logic               Out_Ready
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t             state_q, state_d;
    logic [15:0]        len_q;
    logic [15:0]        issued_q;
    logic [A_WIDTH-1:0] next_addr_q;
    logic               cap_q;
    logic               issue;
    logic               pop;
    logic [CW1-1:0]     owed;
    logic [CW1-1:0]     limit;

    logic [D_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign Sram_RW      = 1'b0;
    assign Sram_Data_In = '0;
    assign Out_Valid    = (count_q != '0);
    assign Out_Data     = Out_Valid ? mem[rd_ptr_q] : '0;
    assign pop          = Out_Valid && Out_Ready;

    // Bytes owed to the buffer: stored + being captured + being read; a pop this edge frees one slot.
    assign owed  = CW1'(count_q) + CW1'(cap_q) + CW1'(Sram_En);
    assign limit = CW1'(FIFO_DEPTH) + CW1'(pop);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) state_d = (Length != 16'd0) ? FETCH : FINISH;
            end
            FETCH: begin
                if (issued_q == len_q) state_d = DRAIN;
                else                   issue   = (owed < limit);
            end
            DRAIN: begin
                if (pop && count_q == CW'(1) && !cap_q) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        Busy = (state_q != IDLE);
        Done = (state_q == FINISH);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            next_addr_q <= '0;
            Sram_En     <= 1'b0;
            Sram_Addr   <= '0;
            cap_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            Sram_En <= issue;
            cap_q   <= Sram_En;
            if (state_q == IDLE && Start) begin
                len_q       <= Length;
                issued_q    <= '0;
                next_addr_q <= Base_Addr;
            end
            if (issue) begin
                Sram_Addr   <= next_addr_q;
                next_addr_q <= next_addr_q + A_WIDTH'(1);
                issued_q    <= issued_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (cap_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({cap_q, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: Out_Data is gated by occupancy.
    always_ff @(posedge Clk) begin
        if (cap_q) mem[wr_ptr_q] <= Sram_Data_Out;
    end

endmodule

// File: doc/sram_operand_reader.md
SRAM_OPERAND_READER -- requirements
Module: sram_operand_reader

Interface
REQ-001 Parameters: A_WIDTH, default 15, SRAM address width; D_WIDTH, default 8, data width; FIFO_DEPTH, default 4, output buffer entries (minimum 3).
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset (Rst=0 resets immediately, independent of Clk).
REQ-004 Start  input  1  request a burst read; sampled only in IDLE.
REQ-005 Base_Addr  input  A_WIDTH  first SRAM address of burst; captured with Start.
REQ-006 Length  input  16  byte count of burst (0..32768); captured with Start.
REQ-007 Busy  output  1  burst in progress.
REQ-008 Done  output  1  one-cycle pulse at burst completion.
REQ-009 Sram_Addr  output  A_WIDTH  address to SRAM Addr.
REQ-010 Sram_En  output  1  to SRAM En.
REQ-011 Sram_RW  output  1  to SRAM RW; constant 0 (read-only initiator).
REQ-012 Sram_Data_In  output  D_WIDTH  to SRAM Data_In; constant 0.
REQ-013 Sram_Data_Out  input  D_WIDTH  from SRAM Data_Out; valid only in the cycle after an edge that sampled Sram_En=1, zero otherwise.
REQ-014 Out_Data  output  D_WIDTH  stream data.
REQ-015 Out_Valid  output  1  stream data valid.
REQ-016 Out_Ready  input  1  downstream accepts; transfer occurs at an edge where Out_Valid=1 and Out_Ready=1.

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN, FINISH.
REQ-018 IDLE: Start=1 at edge -> capture Base_Addr, Length; go FETCH if Length!=0, else FINISH; Start while not IDLE is ignored.
REQ-019 FETCH: issue one read per cycle (Sram_En=1, Sram_Addr=Base_Addr+issued count, modulo 2^A_WIDTH) while issued count < Length and buffer credit available; go DRAIN after the last read is issued.
REQ-020 Credit: a read is issued only if buffer occupancy + reads in flight < FIFO_DEPTH; the buffer never overflows and no SRAM byte is lost or duplicated.
REQ-021 Capture: Sram_Data_Out is written into the buffer at the edge ending the cycle after the issuing edge (fixed 1-cycle SRAM read latency); Sram_Data_Out is never sampled in any other cycle.
REQ-022 DRAIN: no new reads; go FINISH at the edge where the last byte transfers and nothing remains in flight.
REQ-023 FINISH: Done=1 for exactly one cycle, then IDLE; Busy=1 in FETCH, DRAIN and FINISH, 0 in IDLE.
REQ-024 Ordering: bytes leave on Out_Data in increasing address order (with wrap from 2^A_WIDTH-1 to 0).
REQ-025 Latency: with Out_Ready=1, first Out_Valid asserted 3 cycles after the Start edge; sustained throughput 1 byte/cycle.
REQ-026 Backpressure: while Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid hold stable; reads stall when credit is exhausted.
REQ-027 Simultaneous push and pop in one cycle are both performed; occupancy unchanged.
REQ-028 Sram_En=0 in IDLE, DRAIN, FINISH and whenever credit or count blocks issue.

Reset
REQ-029 Rst=0 asynchronously forces: state IDLE, Busy=0, Done=0, Sram_En=0, Sram_Addr=0, Out_Valid=0, Out_Data=0, buffer empty, counters 0.
REQ-030 Reset mid-burst aborts the burst with no Done pulse; after release the block accepts a new Start normally and any in-flight SRAM byte is discarded.

Verification
REQ-031 SRAM preloaded 0x10..0x17 at 0x0100..0x0107; Start, Base_Addr=0x0100, Length=8, Out_Ready=1 -> Out_Data 0x10..0x17 on 8 consecutive cycles, first 3 cycles after Start, Done one cycle after the last transfer.
REQ-032 Same burst, Out_Ready toggling 1,0,0,1 repeating -> same 8 bytes in order, no loss/duplication, Out_Data stable while stalled, Sram_En never issues beyond FIFO_DEPTH outstanding.
REQ-033 Base_Addr=0x7FFE, Length=4 -> reads at 0x7FFE, 0x7FFF, 0x0000, 0x0001 in that order.
REQ-034 Length=0 -> Done pulse 1 cycle after Start, Sram_En never asserted, Out_Valid stays 0.
REQ-035 Rst=0 asserted mid-burst between edges -> all outputs reach reset values before the next edge, no Done; subsequent Start, Length=2 completes correctly.
REQ-036 Start pulsed again while Busy=1 -> ignored; only the original burst's bytes and one Done observed.
